// File: rtl/dac_trig_gen.sv
// dac_trig_gen: trigger sequencer feeding the DAC waveform block's i_sync.
// Picks one trigger source (internal timer, external pin or software strobe),
// enforces a hold-off after every trigger, counts finite or continuous bursts
// and issues a single-cycle o_sync pulse in the DAC clock domain.
// Optional build macro: DAC_TRIG_GLITCH_FILTER_EN adds a 4-sample stability
// filter on the synchronised external pin (adds 4 cycles of latency).
module dac_trig_gen #(
   parameter int CNT_W = 16,
   parameter int PER_W = 32
) (
   input  logic             i_clk,
   input  logic             i_clr_n,
   input  logic [1:0]       i_src,
   input  logic             i_edge,
   input  logic [PER_W-1:0] i_period,
   input  logic [CNT_W-1:0] i_holdoff,
   input  logic [CNT_W-1:0] i_burst,
   input  logic             i_arm,
   input  logic             i_abort,
   input  logic             i_sw_trig,
   input  logic             i_ext_trig,
   output logic             o_sync,
   output logic             o_busy,
   output logic             o_done,
   output logic [CNT_W-1:0] o_trig_cnt,
   output logic [CNT_W-1:0] o_missed
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   localparam logic [1:0]       SRC_INT  = 2'd0;
   localparam logic [1:0]       SRC_EXT  = 2'd1;
   localparam logic [1:0]       SRC_SW   = 2'd2;
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [PER_W-1:0] PER_ZERO = {PER_W{1'b0}};
   localparam logic [PER_W-1:0] PER_ONE  = {{(PER_W-1){1'b0}}, 1'b1};

   state_t           state_r, state_s;
   logic [1:0]       src_r, src_s;
   logic             edge_r, edge_s;
   logic [PER_W-1:0] period_r, period_s;
   logic [CNT_W-1:0] holdoff_r, holdoff_s;
   logic [CNT_W-1:0] burst_r, burst_s;
   logic [PER_W-1:0] per_cnt_r, per_cnt_s, per_next_s;
   logic [CNT_W-1:0] hold_cnt_r, hold_cnt_s;
   logic [CNT_W-1:0] trig_cnt_r, trig_cnt_s, trig_inc_s;
   logic [CNT_W-1:0] missed_r, missed_s;
   logic             sync_r, sync_s;
   logic             done_r, done_s;
   logic             busy_r, busy_s;
   logic [2:0]       z_r;
   logic             ext_cur_s, ext_prv_s;
   logic             evt_s;

   // Three-flop synchroniser for the asynchronous external trigger pin.
   always_ff @(posedge i_clk or negedge i_clr_n) begin
      if (!i_clr_n) begin
         z_r <= 3'b000;
      end else begin
         z_r <= {z_r[1:0], i_ext_trig};
      end
   end

`ifdef DAC_TRIG_GLITCH_FILTER_EN
   logic       flt_r;
   logic       flt_d_r;
   logic [1:0] flt_cnt_r;

   // Filtered level follows z[1] only after four consecutive differing samples.
   always_ff @(posedge i_clk or negedge i_clr_n) begin
      if (!i_clr_n) begin
         flt_r     <= 1'b0;
         flt_d_r   <= 1'b0;
         flt_cnt_r <= 2'd0;
      end else begin
         flt_d_r <= flt_r;
         if (z_r[1] == flt_r) begin
            flt_cnt_r <= 2'd0;
         end else if (flt_cnt_r == 2'd3) begin
            flt_r     <= z_r[1];
            flt_cnt_r <= 2'd0;
         end else begin
            flt_cnt_r <= flt_cnt_r + 2'd1;
         end
      end
   end

   assign ext_cur_s = flt_r;
   assign ext_prv_s = flt_d_r;
`else
   assign ext_cur_s = z_r[1];
   assign ext_prv_s = z_r[2];
`endif

   assign per_next_s = (per_cnt_r == period_r) ? PER_ZERO : (per_cnt_r + PER_ONE);
   assign trig_inc_s = trig_cnt_r + CNT_ONE;

   // Trigger event from the source latched at arm time.
   always_comb begin
      evt_s = 1'b0;
      case (src_r)
         SRC_INT: evt_s = (per_cnt_r == period_r);
         SRC_EXT: evt_s = edge_r ? (~ext_cur_s & ext_prv_s) : (ext_cur_s & ~ext_prv_s);
         SRC_SW:  evt_s = i_sw_trig;
         default: evt_s = 1'b0;
      endcase
   end

   // Next-state, counter and pulse logic; abort overrides arm and events.
   always_comb begin
      state_s    = state_r;
      src_s      = src_r;
      edge_s     = edge_r;
      period_s   = period_r;
      holdoff_s  = holdoff_r;
      burst_s    = burst_r;
      per_cnt_s  = per_cnt_r;
      hold_cnt_s = hold_cnt_r;
      trig_cnt_s = trig_cnt_r;
      missed_s   = missed_r;
      sync_s     = 1'b0;
      done_s     = 1'b0;
      if (i_abort) begin
         state_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (i_arm) begin
                  state_s    = ST_WAIT;
                  src_s      = i_src;
                  edge_s     = i_edge;
                  period_s   = i_period;
                  holdoff_s  = i_holdoff;
                  burst_s    = i_burst;
                  per_cnt_s  = PER_ZERO;
                  trig_cnt_s = CNT_ZERO;
                  missed_s   = CNT_ZERO;
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_WAIT: begin
               per_cnt_s = per_next_s;
               if (evt_s) begin
                  sync_s     = 1'b1;
                  trig_cnt_s = trig_inc_s;
                  hold_cnt_s = holdoff_r - CNT_ONE;
                  if ((burst_r != CNT_ZERO) && (trig_inc_s == burst_r)) begin
                     done_s  = 1'b1;
                     state_s = ST_IDLE;
                  end else if (holdoff_r != CNT_ZERO) begin
                     state_s = ST_HOLD;
                  end else begin
                     state_s = ST_WAIT;
                  end
               end else begin
                  state_s = ST_WAIT;
               end
            end
            ST_HOLD: begin
               per_cnt_s = per_next_s;
               if (evt_s && (missed_r != CNT_MAX)) begin
                  missed_s = missed_r + CNT_ONE;
               end else begin
                  missed_s = missed_r;
               end
               if (hold_cnt_r == CNT_ZERO) begin
                  state_s = ST_WAIT;
               end else begin
                  hold_cnt_s = hold_cnt_r - CNT_ONE;
               end
            end
            default: begin
               state_s = ST_IDLE;
            end
         endcase
      end
      busy_s = (state_s != ST_IDLE);
   end

   // State, shadow configuration, counters and registered outputs.
   always_ff @(posedge i_clk or negedge i_clr_n) begin
      if (!i_clr_n) begin
         state_r    <= ST_IDLE;
         src_r      <= 2'd0;
         edge_r     <= 1'b0;
         period_r   <= PER_ZERO;
         holdoff_r  <= CNT_ZERO;
         burst_r    <= CNT_ZERO;
         per_cnt_r  <= PER_ZERO;
         hold_cnt_r <= CNT_ZERO;
         trig_cnt_r <= CNT_ZERO;
         missed_r   <= CNT_ZERO;
         sync_r     <= 1'b0;
         done_r     <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         src_r      <= src_s;
         edge_r     <= edge_s;
         period_r   <= period_s;
         holdoff_r  <= holdoff_s;
         burst_r    <= burst_s;
         per_cnt_r  <= per_cnt_s;
         hold_cnt_r <= hold_cnt_s;
         trig_cnt_r <= trig_cnt_s;
         missed_r   <= missed_s;
         sync_r     <= sync_s;
         done_r     <= done_s;
         busy_r     <= busy_s;
      end
   end

   assign o_sync     = sync_r;
   assign o_busy     = busy_r;
   assign o_done     = done_r;
   assign o_trig_cnt = trig_cnt_r;
   assign o_missed   = missed_r;

endmodule

// File: doc/dac_trig_gen.md
# dac_trig_gen

Trigger sequencer that drives the `i_sync` input of the DAC waveform block.
- Selects one trigger source: internal periodic timer, external pin, or software strobe.
- Synchronises and edge-detects the external pin.
- Enforces a programmable hold-off between triggers.
- Counts a finite or continuous burst of triggers per arm.
- Emits a single-cycle `o_sync` pulse in the DAC clock domain.

Configuration values come from the common register bank.

## Interface
Parameters:
- CNT_W, 16, width of burst, hold-off, trigger and missed counters
- PER_W, 32, width of internal period value

Ports:
- i_clk  in  1  DAC sample clock; all logic on rising edge
- i_clr_n  in  1  asynchronous active-low reset
- i_src  in  2  source: 0 internal, 1 external, 2 software, 3 none
- i_edge  in  1  external edge: 0 rising, 1 falling
- i_period  in  PER_W  internal interval minus one (interval = P+1 cycles)
- i_holdoff  in  CNT_W  hold-off cycles after each o_sync
- i_burst  in  CNT_W  triggers per arm; 0 = continuous
- i_arm  in  1  one-cycle strobe: start a sequence
- i_abort  in  1  one-cycle strobe: stop immediately
- i_sw_trig  in  1  one-cycle software trigger strobe
- i_ext_trig  in  1  asynchronous external trigger pin
- o_sync  out  1  one-cycle trigger pulse to DAC block
- o_busy  out  1  high in WAIT or HOLD
- o_done  out  1  one-cycle pulse when finite burst completes
- o_trig_cnt  out  CNT_W  triggers issued since arm
- o_missed  out  CNT_W  events ignored during HOLD, saturating

## Operation
- Reset: state IDLE. All outputs 0, all counters 0, synchroniser flops 0.
- States and transitions:
  - IDLE: i_arm → WAIT.
  - WAIT: accepted event → HOLD if latched hold-off ≠ 0, else stay WAIT. If the event is the last of a finite burst → IDLE instead.
  - HOLD: hold-off counter reaches 0 → WAIT.
- Arm (IDLE only):
  - Latches i_src, i_edge, i_period, i_holdoff and i_burst into shadow registers.
  - Clears o_trig_cnt, o_missed and the period counter.
  - Input changes while busy have no effect until the next arm.
  - i_arm in WAIT or HOLD is ignored.
- Abort: i_abort → IDLE from any state, next edge. No o_done. Counters hold their values. Abort beats arm and events in the same cycle.
- Events (evt, combinational from the latched source):
  - Internal: period counter runs only in WAIT/HOLD and counts 0..P. evt when counter == P, then it wraps to 0. Wrap is free-running and independent of hold-off.
  - External: i_ext_trig passes through a 3-flop synchroniser z[2:0]. Rising: evt = z[1] & ~z[2]. Falling: evt = ~z[1] & z[2].
  - Software: evt = i_sw_trig.
  - Source 3: never.
- Accepted event in WAIT:
  - Next edge: o_sync = 1 for one cycle and o_trig_cnt increments.
  - Hold-off counter loads H−1.
- Burst completion: when o_trig_cnt+1 == burst (burst ≠ 0), o_done pulses in the same cycle as that o_sync and the state goes to IDLE.
- Continuous mode (burst 0): o_trig_cnt wraps FFFF→0.
- Missed events: evt in HOLD increments o_missed, saturating at all-ones. evt in IDLE is ignored and not counted.
- Arm and evt in the same cycle: arm wins; the event is dropped.

## Timing
- Software: i_sw_trig high at edge n → o_sync high from edge n+1 to n+2.
- Internal: o_sync spacing is exactly P+1 cycles when hold-off < P+1.
  - First o_sync comes P+1 cycles after the edge that accepts i_arm.
- External: a pin edge meeting setup at edge n → o_sync asserted at edge n+3, one cycle wide.
  - With filter enabled: n+3+FILT (FILT = 4).
- Hold-off H: minimum o_sync spacing is H+1 cycles. H = 0 allows o_sync on consecutive cycles.
- o_busy: registered, rises one edge after the arm edge, falls on the edge that enters IDLE.
- Reset assertion mid-sequence: o_sync and o_done drop asynchronously; no pulse is truncated into a second cycle.

## Configuration
- DAC_TRIG_GLITCH_FILTER_EN:
  - Defined: the synchronised external level must be stable for 4 consecutive cycles before it updates the filtered level used for edge detection. Pulses shorter than 4 cycles are rejected. Latency is +4 cycles.
  - Undefined: no filter; edge detection works on z[2:1] directly.
  - Internal and software paths are identical in both builds.

## Test plan
- Internal, P=9, H=0, burst=3, arm → o_sync at 10, 20, 30 cycles after arm; o_done with the third pulse; o_trig_cnt=3; o_busy low after.
- Software, H=5, burst=0, sw_trig every 2 cycles for 20 cycles → o_sync every 6 cycles; o_missed = (accepted−1)×2; busy remains high.
- External rising, no filter, pin 0→1 → o_sync exactly 3 edges later. Falling mode ignores the same edge. With filter, a 2-cycle glitch produces no o_sync.
- Abort in HOLD with burst=5 after 2 triggers → IDLE next edge, no o_done, o_trig_cnt stays 2; i_arm in the same cycle as abort is ignored.
- Re-arm clears o_trig_cnt/o_missed. Changing i_period while busy does not alter spacing. Async reset mid-HOLD → all outputs 0 immediately.
- Arm and sw_trig in the same cycle → no o_sync; the next sw_trig produces o_sync at +1 cycle.
